// File: rtl/seg_scan_if.sv
// Scanned 7-segment display bus: raw active-low lines from the driver side and
// the per-digit values recovered by the receiver.
interface seg_scan_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    logic [7:0]              segments_n;
    logic [NUM_DIGITS-1:0]   digit_n;
    logic [4*NUM_DIGITS-1:0] hex_out;
    logic [NUM_DIGITS-1:0]   dp_out;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic [NUM_DIGITS-1:0]   code_err;
    logic                    update;
    logic [IDX_W-1:0]        update_idx;

    modport master (
        output segments_n, digit_n,
        input  hex_out, dp_out, digit_valid, code_err, update, update_idx
    );

    modport slave (
        input  segments_n, digit_n,
        output hex_out, dp_out, digit_valid, code_err, update, update_idx
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Receive side of a scanned 7-segment bus: synchronises the lines, waits for a
// stable one-hot digit enable and captures the decoded glyph into that digit.
module seg_scan_decoder #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic     clk,
    input  logic     reset,
    seg_scan_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
    localparam int unsigned W     = NUM_DIGITS + 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StCapture, StHold} state_e;

    state_e                  state_q;
    logic [W-1:0]            sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [4*NUM_DIGITS-1:0] hex_q;
    logic [NUM_DIGITS-1:0]   dp_q, valid_q, err_q;
    logic                    update_q;
    logic [IDX_W-1:0]        update_idx_q;

    logic [NUM_DIGITS-1:0] s_dig;
    logic [6:0]            s_seg;
    logic                  s_dp, s_onehot, chg, dec_ok;
    logic [3:0]            dec_val;
    logic [IDX_W-1:0]      idx;

    assign s_dig    = ~sync2_q[W-1:8];
    assign s_seg    = ~sync2_q[6:0];
    assign s_dp     = ~sync2_q[7];
    assign s_onehot = $onehot(s_dig);
    assign chg      = (sync2_q != prev_q);

    always_comb begin
        idx = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (s_dig[i]) idx = IDX_W'(i);
        end
    end

    always_comb begin
        dec_ok  = 1'b1;
        dec_val = 4'h0;
        case (s_seg)
            7'h3F: dec_val = 4'h0;
            7'h06: dec_val = 4'h1;
            7'h5B: dec_val = 4'h2;
            7'h4F: dec_val = 4'h3;
            7'h66: dec_val = 4'h4;
            7'h6D: dec_val = 4'h5;
            7'h7D: dec_val = 4'h6;
            7'h07: dec_val = 4'h7;
            7'h7F: dec_val = 4'h8;
            7'h6F: dec_val = 4'h9;
            7'h77: dec_val = 4'hA;
            7'h7C: dec_val = 4'hB;
            7'h39: dec_val = 4'hC;
            7'h5E: dec_val = 4'hD;
            7'h79: dec_val = 4'hE;
            7'h71: dec_val = 4'hF;
            default: dec_ok = 1'b0;
        endcase
    end

    // Idle bus is all-ones, so the synchroniser resets to that value.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= {bus.digit_n, bus.segments_n};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (chg)                 cnt_q <= '0;
            else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        end
    end

    // Digit registers are written on the edge entering StCapture, so they are
    // already valid in the cycle update is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            hex_q        <= '0;
            dp_q         <= '0;
            valid_q      <= '0;
            err_q        <= '0;
            update_q     <= 1'b0;
            update_idx_q <= '0;
        end else begin
            update_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (chg && s_onehot) state_q <= StSettle;
                end
                StSettle: begin
                    if (chg) begin
                        state_q <= s_onehot ? StSettle : StIdle;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q      <= StCapture;
                        update_q     <= 1'b1;
                        update_idx_q <= idx;
                        dp_q[idx]    <= s_dp;
                        valid_q[idx] <= dec_ok;
                        err_q[idx]   <= ~dec_ok;
                        if (dec_ok) hex_q[idx*4 +: 4] <= dec_val;
                    end
                end
                StCapture, StHold: begin
                    if (chg) state_q <= s_onehot ? StSettle : StIdle;
                    else     state_q <= StHold;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.hex_out     = hex_q;
    assign bus.dp_out      = dp_q;
    assign bus.digit_valid = valid_q;
    assign bus.code_err    = err_q;
    assign bus.update      = update_q;
    assign bus.update_idx  = update_idx_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: capture latency, scanning, illegal glyphs,
// glitch rejection, non-one-hot enables and reset during settling.
module tb_seg_scan_decoder;
    localparam int LAT = 19; // first sampling edge counted as 1; update seen after edge N+18

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   upd_cnt  = 0;
    int   idx_log[$];

    always #5 clk = ~clk;

    seg_scan_if #(.NUM_DIGITS(4)) bus ();

    seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(negedge clk) begin
        if (bus.update) begin
            upd_cnt++;
            idx_log.push_back(int'(bus.update_idx));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [3:0] dn, input logic [7:0] sn);
        @(negedge clk);
        bus.digit_n    = dn;
        bus.segments_n = sn;
    endtask

    task automatic measure(output int edges);
        bit found = 0;
        edges = -1;
        for (int k = 1; k <= 60 && !found; k++) begin
            @(posedge clk);
            #1;
            if (bus.update) begin
                edges = k;
                found = 1;
            end
        end
    endtask

    initial begin
        int         lat;
        int         base;
        logic [7:0] sn;
        logic [7:0] glyph[4];
        glyph = '{8'h7F, 8'h6D, 8'h06, 8'h71};

        // Reset values
        reset          = 1'b1;
        bus.digit_n    = 4'hF;
        bus.segments_n = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hex", 32'(bus.hex_out), 32'h0);
        check("rst_valid", 32'(bus.digit_valid), 32'h0);
        check("rst_err", 32'(bus.code_err), 32'h0);
        check("rst_dp", 32'(bus.dp_out), 32'h0);
        check("rst_update", 32'(bus.update), 32'h0);
        check("rst_idx", 32'(bus.update_idx), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // 1: single capture and latency
        apply(4'b1110, ~8'h3F);
        measure(lat);
        check("t1_latency", 32'(lat), 32'(LAT));
        check("t1_idx", 32'(bus.update_idx), 32'h0);
        check("t1_hex0", 32'(bus.hex_out[3:0]), 32'h0);
        check("t1_valid", 32'(bus.digit_valid), 32'h1);
        check("t1_err", 32'(bus.code_err), 32'h0);
        repeat (40) @(posedge clk);
        check("t1_single_pulse", 32'(upd_cnt), 32'h1);

        // 2: scan four digits
        base = upd_cnt;
        idx_log.delete();
        for (int i = 0; i < 4; i++) begin
            apply(4'(~(4'b0001 << i)), ~glyph[i]);
            repeat (40) @(posedge clk);
        end
        #1;
        check("t2_hex", 32'(bus.hex_out), 32'hF158);
        check("t2_valid", 32'(bus.digit_valid), 32'hF);
        check("t2_err", 32'(bus.code_err), 32'h0);
        check("t2_updates", 32'(upd_cnt - base), 32'h4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_idx%0d", i), 32'(idx_log.size() > i ? idx_log[i] : -1), 32'(i));
        end

        // 3: dash on digit 2 keeps old value, then a legal glyph
        apply(4'b1011, ~8'h6D);
        repeat (40) @(posedge clk);
        apply(4'b1011, ~8'h40);
        repeat (40) @(posedge clk);
        #1;
        check("t3_dash_hex", 32'(bus.hex_out[11:8]), 32'h5);
        check("t3_dash_valid", 32'(bus.digit_valid), 32'hB);
        check("t3_dash_err", 32'(bus.code_err), 32'h4);
        apply(4'b1011, ~8'h4F);
        repeat (40) @(posedge clk);
        #1;
        check("t3_hex", 32'(bus.hex_out), 32'hF358);
        check("t3_valid", 32'(bus.digit_valid), 32'hF);
        check("t3_err", 32'(bus.code_err), 32'h0);

        // 4: glitching segment never settles
        base = upd_cnt;
        sn   = ~8'h7F;
        for (int k = 0; k < 20; k++) begin
            apply(4'b1101, sn);
            repeat (4) @(negedge clk);
            sn[0] = ~sn[0];
        end
        check("t4_no_update", 32'(upd_cnt - base), 32'h0);
        apply(4'b1101, ~8'h7F);
        measure(lat);
        check("t4_latency", 32'(lat), 32'(LAT));
        check("t4_idx", 32'(bus.update_idx), 32'h1);
        check("t4_hex", 32'(bus.hex_out), 32'hF388);

        // 5: zero or several enables never capture
        repeat (5) @(posedge clk);
        base = upd_cnt;
        apply(4'b1100, ~8'h06);
        repeat (100) @(posedge clk);
        apply(4'b1111, ~8'h06);
        repeat (100) @(posedge clk);
        #1;
        check("t5_no_update", 32'(upd_cnt - base), 32'h0);
        check("t5_hex", 32'(bus.hex_out), 32'hF388);
        check("t5_valid", 32'(bus.digit_valid), 32'hF);
        check("t5_err", 32'(bus.code_err), 32'h0);

        // 6: reset while the counter is at STABLE_CYCLES-2, dp on
        base = upd_cnt;
        apply(4'b0111, {1'b0, ~7'h06});
        repeat (17) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_update", 32'(upd_cnt - base), 32'h0);
        check("t6_rst_hex", 32'(bus.hex_out), 32'h0);
        check("t6_rst_valid", 32'(bus.digit_valid), 32'h0);
        check("t6_rst_dp", 32'(bus.dp_out), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        measure(lat);
        check("t6_latency", 32'(lat), 32'(LAT));
        check("t6_idx", 32'(bus.update_idx), 32'h3);
        check("t6_hex", 32'(bus.hex_out), 32'h1000);
        check("t6_dp", 32'(bus.dp_out), 32'h8);
        check("t6_valid", 32'(bus.digit_valid), 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
